// File: rtl/mult_4x4.sv
// Unsigned 4x4 array multiplier: AND-gate partial products reduced by three rows of
// ripple adders built from explicit half/full adder cells, with a registered 8-bit product.

module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   assign o_s  = i_a ^ i_b ^ i_ci;
   assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module mult_4x4 (
   input  logic clk,
   input  logic rst,
   input  logic A0,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   input  logic B0,
   input  logic B1,
   input  logic B2,
   input  logic B3,
   output logic product0,
   output logic product1,
   output logic product2,
   output logic product3,
   output logic product4,
   output logic product5,
   output logic product6,
   output logic product7
);
   logic [3:0] w_a;
   logic [3:0] w_b;
   logic [3:0] w_pp0, w_pp1, w_pp2, w_pp3;   // w_ppJ[i] = A[i] & B[J]
   logic [3:0] w_s1, w_s2, w_s3;             // row sums
   logic [3:0] w_c1, w_c2, w_c3;             // row ripple carries; [3] is the row carry-out
   logic [7:0] w_p;
   logic [7:0] r_p;

   assign w_a   = {A3, A2, A1, A0};
   assign w_b   = {B3, B2, B1, B0};
   assign w_pp0 = w_a & {4{w_b[0]}};
   assign w_pp1 = w_a & {4{w_b[1]}};
   assign w_pp2 = w_a & {4{w_b[2]}};
   assign w_pp3 = w_a & {4{w_b[3]}};

   // Row 1: (pp0 >> 1) + pp1; the top cell has no pp0 bit so it is a half adder.
   half_adder u_r1_0 (.i_a(w_pp1[0]), .i_b(w_pp0[1]), .o_s(w_s1[0]), .o_c(w_c1[0]));
   full_adder u_r1_1 (.i_a(w_pp1[1]), .i_b(w_pp0[2]), .i_ci(w_c1[0]), .o_s(w_s1[1]), .o_co(w_c1[1]));
   full_adder u_r1_2 (.i_a(w_pp1[2]), .i_b(w_pp0[3]), .i_ci(w_c1[1]), .o_s(w_s1[2]), .o_co(w_c1[2]));
   half_adder u_r1_3 (.i_a(w_pp1[3]), .i_b(w_c1[2]), .o_s(w_s1[3]), .o_c(w_c1[3]));

   // Row 2: ({c1_out, s1[3:1]}) + pp2
   half_adder u_r2_0 (.i_a(w_pp2[0]), .i_b(w_s1[1]), .o_s(w_s2[0]), .o_c(w_c2[0]));
   full_adder u_r2_1 (.i_a(w_pp2[1]), .i_b(w_s1[2]), .i_ci(w_c2[0]), .o_s(w_s2[1]), .o_co(w_c2[1]));
   full_adder u_r2_2 (.i_a(w_pp2[2]), .i_b(w_s1[3]), .i_ci(w_c2[1]), .o_s(w_s2[2]), .o_co(w_c2[2]));
   full_adder u_r2_3 (.i_a(w_pp2[3]), .i_b(w_c1[3]), .i_ci(w_c2[2]), .o_s(w_s2[3]), .o_co(w_c2[3]));

   // Row 3: ({c2_out, s2[3:1]}) + pp3
   half_adder u_r3_0 (.i_a(w_pp3[0]), .i_b(w_s2[1]), .o_s(w_s3[0]), .o_c(w_c3[0]));
   full_adder u_r3_1 (.i_a(w_pp3[1]), .i_b(w_s2[2]), .i_ci(w_c3[0]), .o_s(w_s3[1]), .o_co(w_c3[1]));
   full_adder u_r3_2 (.i_a(w_pp3[2]), .i_b(w_s2[3]), .i_ci(w_c3[1]), .o_s(w_s3[2]), .o_co(w_c3[2]));
   full_adder u_r3_3 (.i_a(w_pp3[3]), .i_b(w_c2[3]), .i_ci(w_c3[2]), .o_s(w_s3[3]), .o_co(w_c3[3]));

   assign w_p = {w_c3[3], w_s3, w_s2[0], w_s1[0], w_pp0[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_p <= 8'h00;
      else     r_p <= w_p;
   end

   assign {product7, product6, product5, product4,
           product3, product2, product1, product0} = r_p;
endmodule

// File: tb/tb_mult_4x4.sv
// Directed bench for mult_4x4: reset behaviour, exhaustive sweep, corner operands,
// asynchronous mid-cycle reset and mid-cycle input glitches.

module tb_mult_4x4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic A0 = 1'b0, A1 = 1'b0, A2 = 1'b0, A3 = 1'b0;
   logic B0 = 1'b0, B1 = 1'b0, B2 = 1'b0, B3 = 1'b0;
   logic product0, product1, product2, product3;
   logic product4, product5, product6, product7;
   logic [7:0] w_p;
   int checks = 0;
   int errors = 0;

   mult_4x4 dut (
      .clk(clk), .rst(rst),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3),
      .B0(B0), .B1(B1), .B2(B2), .B3(B3),
      .product0(product0), .product1(product1), .product2(product2), .product3(product3),
      .product4(product4), .product5(product5), .product6(product6), .product7(product7)
   );

   assign w_p = {product7, product6, product5, product4, product3, product2, product1, product0};

   always #5 clk = ~clk;

   task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
      {A3, A2, A1, A0} = a;
      {B3, B2, B1, B0} = b;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      checks++;
      assert (w_p === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, w_p, exp);
      end
   endtask

   // Drive operands away from the edge, then check one edge later.
   task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
      @(negedge clk);
      set_ab(a, b);
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      // 1. Reset holds output at zero while the clock runs.
      set_ab(4'hF, 4'hF);
      #1;
      check("reset_t0", 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_clk", 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_pre_edge", 8'h00);
      @(posedge clk);
      #1;
      check("release_first_edge", 8'hE1);

      // 2. Exhaustive sweep, A fastest.
      for (int b = 0; b < 16; b++) begin
         for (int a = 0; a < 16; a++) begin
            logic [7:0] exp_v;
            exp_v = 8'(a * b);
            apply("sweep", 4'(a), 4'(b), exp_v);
         end
      end
      apply("sweep_7x9", 4'd7, 4'd9, 8'h3F);

      // 3. Zero and identity.
      apply("zero_a", 4'd0, 4'd13, 8'h00);
      apply("ident_a1", 4'd1, 4'd13, 8'h0D);
      apply("ident_b1", 4'd13, 4'd1, 8'h0D);

      // 4. Carry chain corners.
      apply("carry_15x8", 4'd15, 4'd8, 8'h78);
      apply("carry_8x8", 4'd8, 4'd8, 8'h40);
      apply("carry_15x15", 4'd15, 4'd15, 8'hE1);

      // 5. Asynchronous reset between edges.
      #3;
      check("pre_async_rst", 8'hE1);
      rst = 1'b1;
      #1;
      check("async_rst_immediate", 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("async_rst_hold", 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rst_release_pre_edge", 8'h00);
      @(posedge clk);
      #1;
      check("async_rst_release_edge", 8'hE1);

      // 6. Mid-cycle glitch does not reach the outputs.
      apply("glitch_base", 4'd6, 4'd5, 8'h1E);
      #2;
      set_ab(4'd15, 4'd15);
      #2;
      check("glitch_during", 8'h1E);
      set_ab(4'd6, 4'd5);
      #2;
      check("glitch_after", 8'h1E);
      @(posedge clk);
      #1;
      check("glitch_next_edge", 8'h1E);
      #3;
      set_ab(4'd3, 4'd11);
      #2;
      check("midcycle_change_hold", 8'h1E);
      @(posedge clk);
      #1;
      check("midcycle_change_edge", 8'h21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
